// File: rtl/seg_pkg.sv
// Shared 7-segment definitions used by the display encoder and the capture block.
// Segment codes are active low, bit order g..a.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_NONE  = 4'hF;
    localparam int         DP_BIT    = 7;

    typedef struct packed {
        logic       legal;
        logic [3:0] bcd;
    } seg_dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD decode with a legal-code flag.
module seg7_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output seg_dec_t   dec
);

    always_comb begin
        dec = '{legal: 1'b0, bcd: BCD_NONE};
        case (seg)
            SEG_0:     dec = '{legal: 1'b1, bcd: 4'd0};
            SEG_1:     dec = '{legal: 1'b1, bcd: 4'd1};
            SEG_2:     dec = '{legal: 1'b1, bcd: 4'd2};
            SEG_3:     dec = '{legal: 1'b1, bcd: 4'd3};
            SEG_4:     dec = '{legal: 1'b1, bcd: 4'd4};
            SEG_5:     dec = '{legal: 1'b1, bcd: 4'd5};
            SEG_6:     dec = '{legal: 1'b1, bcd: 4'd6};
            SEG_7:     dec = '{legal: 1'b1, bcd: 4'd7};
            SEG_8:     dec = '{legal: 1'b1, bcd: 4'd8};
            SEG_9:     dec = '{legal: 1'b1, bcd: 4'd9};
            // an unlit digit carries no value, so it reports as illegal
            SEG_BLANK: dec = '{legal: 1'b0, bcd: BCD_NONE};
            default:   dec = '{legal: 1'b0, bcd: BCD_NONE};
        endcase
    end

endmodule

// File: rtl/seg8_to_bcd_capture.sv
// Receive side of the multiplexed 7-segment bus: synchronizes segment/anode lines,
// waits for a stable pattern and rebuilds per-digit BCD, DP and error flags plus frame pulses.
module seg8_to_bcd_capture
    import seg_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   digits_o,
    output logic [DIGITS-1:0]     dp_o,
    output logic [DIGITS-1:0]     digit_err_o,
    output logic                  frame_valid_o,
    output logic                  an_err_o
);

    localparam int SW = DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYC + 1);

    logic [SW-1:0]     sync1, s2, prev;
    logic [CW-1:0]     cnt;
    logic [DIGITS-1:0] seen;

    logic [DIGITS-1:0] an_low;
    logic [7:0]        s2_seg;
    logic              an_none, an_multi, capture;
    seg_dec_t          dec;

    assign s2_seg  = s2[7:0];
    assign an_low  = ~s2[SW-1:8];
    assign an_none = (an_low == '0);
    // clearing the lowest set bit leaves something only if two or more anodes are active
    assign an_multi = ((an_low & (an_low - 1'b1)) != '0);
    assign capture  = (s2 == prev) && (cnt == CW'(STABLE_CYC - 1));

    seg7_pattern_decode u_decode (
        .seg (s2_seg[6:0]),
        .dec (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            s2    <= '1;
            prev  <= '1;
            cnt   <= '0;
        end else begin
            sync1 <= {an_in, seg_in};
            s2    <= sync1;
            prev  <= s2;
            if (s2 != prev)
                cnt <= '0;
            else if (cnt < CW'(STABLE_CYC))
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_o      <= {DIGITS{BCD_NONE}};
            dp_o          <= '0;
            digit_err_o   <= '0;
            frame_valid_o <= 1'b0;
            an_err_o      <= 1'b0;
            seen          <= '0;
        end else begin
            frame_valid_o <= 1'b0;
            an_err_o      <= 1'b0;
            if (capture) begin
                if (an_multi) begin
                    an_err_o <= 1'b1;
                end else if (!an_none) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (an_low[i]) begin
                            digits_o[4*i +: 4] <= dec.legal ? dec.bcd : BCD_NONE;
                            digit_err_o[i]     <= ~dec.legal;
                            dp_o[i]            <= ~s2_seg[DP_BIT];
                        end
                    end
                    if ((seen | an_low) == '1) begin
                        frame_valid_o <= 1'b1;
                        seen          <= '0;
                    end else begin
                        seen <= seen | an_low;
                    end
                end
            end
        end
    end

endmodule
